// File: rtl/ov5640_capture_pkg.sv
// Shared definitions for the OV5640 capture path and the display read side.
// Holds the capture FSM encoding and the default frame geometry.
package ov5640_capture_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_CFG = 2'd0,
        ST_SKIP     = 2'd1,
        ST_CAPTURE  = 2'd2
    } cap_state_e;

    localparam int FRAME_SKIP_DEF = 10;
    localparam int H_PIXEL_DEF    = 640;
    localparam int V_PIXEL_DEF    = 480;

endpackage

// File: rtl/ov5640_capture_if.sv
// DVP sensor inputs and RGB565 write-side outputs of the capture block.
// The master side drives the sensor pins; the slave side is the capture logic.
interface ov5640_capture_if;

    logic        cfg_done;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        pix_wr_en;
    logic [15:0] pix_data;
    logic        frame_rst;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        geom_err;

    modport master (
        output cfg_done, cam_vsync, cam_href, cam_data,
        input  pix_wr_en, pix_data, frame_rst, frame_done, frame_cnt, geom_err
    );

    modport slave (
        input  cfg_done, cam_vsync, cam_href, cam_data,
        output pix_wr_en, pix_data, frame_rst, frame_done, frame_cnt, geom_err
    );

endinterface

// File: rtl/ov5640_capture.sv
// OV5640 DVP capture: skips warm-up frames, pairs bytes into RGB565 words and
// tracks frame geometry. All logic runs on the camera PCLK.
//
//   state       | meaning
//   ST_WAIT_CFG | sensor not configured; no capture
//   ST_SKIP     | counting vsync edges to discard unstable frames
//   ST_CAPTURE  | pairing bytes, writing words, checking geometry
module ov5640_capture
    import ov5640_capture_pkg::*;
#(
    parameter int FRAME_SKIP = FRAME_SKIP_DEF,
    parameter int H_PIXEL    = H_PIXEL_DEF,
    parameter int V_PIXEL    = V_PIXEL_DEF
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    ov5640_capture_if.slave cam
);

    localparam logic [7:0]  SKIP_LAST = 8'(FRAME_SKIP - 1);
    localparam logic [10:0] H_CNT     = 11'(H_PIXEL);
    localparam logic [9:0]  V_CNT     = 10'(V_PIXEL);

    cap_state_e  state_q;
    logic        vsync_s1_q, href_s1_q;
    logic [7:0]  data_s1_q;
    logic        vsync_prev_q, href_prev_q;
    logic [7:0]  skip_cnt_q;
    logic        phase_q;
    logic [7:0]  hi_byte_q;
    logic [10:0] pix_cnt_q;
    logic [9:0]  line_cnt_q;
    logic        pix_wr_en_q, frame_rst_q, frame_done_q, geom_err_q;
    logic [15:0] pix_data_q;
    logic [7:0]  frame_cnt_q;

    logic vsync_rise, href_fall, line_byte;

    // href activity during vsync is blanking noise and is neither written nor counted
    assign vsync_rise = vsync_s1_q & ~vsync_prev_q;
    assign href_fall  = href_prev_q & ~href_s1_q & ~vsync_s1_q;
    assign line_byte  = href_s1_q & ~vsync_s1_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_WAIT_CFG;
            vsync_s1_q   <= 1'b0;
            href_s1_q    <= 1'b0;
            data_s1_q    <= 8'h00;
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            skip_cnt_q   <= 8'h00;
            phase_q      <= 1'b0;
            hi_byte_q    <= 8'h00;
            pix_cnt_q    <= 11'd0;
            line_cnt_q   <= 10'd0;
            pix_wr_en_q  <= 1'b0;
            pix_data_q   <= 16'h0000;
            frame_rst_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'h00;
            geom_err_q   <= 1'b0;
        end else begin
            vsync_s1_q   <= cam.cam_vsync;
            href_s1_q    <= cam.cam_href;
            data_s1_q    <= cam.cam_data;
            vsync_prev_q <= vsync_s1_q;
            href_prev_q  <= href_s1_q;
            pix_wr_en_q  <= 1'b0;
            frame_rst_q  <= 1'b0;
            frame_done_q <= 1'b0;

            if (!cam.cfg_done) begin
                state_q    <= ST_WAIT_CFG;
                phase_q    <= 1'b0;
                pix_cnt_q  <= 11'd0;
                line_cnt_q <= 10'd0;
            end else begin
                case (state_q)
                    ST_WAIT_CFG: begin
                        state_q    <= ST_SKIP;
                        skip_cnt_q <= 8'h00;
                    end
                    ST_SKIP: begin
                        if (vsync_rise) begin
                            if (skip_cnt_q == SKIP_LAST) begin
                                state_q     <= ST_CAPTURE;
                                frame_rst_q <= 1'b1;
                                line_cnt_q  <= 10'd0;
                                pix_cnt_q   <= 11'd0;
                                phase_q     <= 1'b0;
                            end else begin
                                skip_cnt_q <= skip_cnt_q + 8'd1;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (line_byte) begin
                            if (!phase_q) begin
                                hi_byte_q <= data_s1_q;
                                phase_q   <= 1'b1;
                            end else begin
                                pix_data_q  <= {hi_byte_q, data_s1_q};
                                pix_wr_en_q <= 1'b1;
                                pix_cnt_q   <= pix_cnt_q + 11'd1;
                                phase_q     <= 1'b0;
                            end
                        end else begin
                            phase_q <= 1'b0;
                        end

                        if (href_fall) begin
                            line_cnt_q <= line_cnt_q + 10'd1;
                            pix_cnt_q  <= 11'd0;
                            if (pix_cnt_q != H_CNT || phase_q)
                                geom_err_q <= 1'b1;
                        end

                        if (vsync_rise) begin
                            frame_done_q <= 1'b1;
                            frame_rst_q  <= 1'b1;
                            frame_cnt_q  <= frame_cnt_q + 8'd1;
                            line_cnt_q   <= 10'd0;
                            if (line_cnt_q != V_CNT)
                                geom_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_WAIT_CFG;
                endcase
            end
        end
    end

    assign cam.pix_wr_en  = pix_wr_en_q;
    assign cam.pix_data   = pix_data_q;
    assign cam.frame_rst  = frame_rst_q;
    assign cam.frame_done = frame_done_q;
    assign cam.frame_cnt  = frame_cnt_q;
    assign cam.geom_err   = geom_err_q;

endmodule

// File: tb/tb_ov5640_capture.sv
// Directed bench for ov5640_capture with a 4x2 frame and a two-frame skip.
// Output strobes are tallied on the falling edge and checked against hand counts.
module tb_ov5640_capture;
    import ov5640_capture_pkg::*;

    localparam int FS = 2;
    localparam int HP = 4;
    localparam int VP = 2;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    ov5640_capture_if ifc ();

    ov5640_capture #(.FRAME_SKIP(FS), .H_PIXEL(HP), .V_PIXEL(VP)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cam       (ifc)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_vec    = 0;
    int          n_err    = 0;
    int          wr_cnt   = 0;
    int          rst_cnt  = 0;
    int          done_cnt = 0;
    int          both_cnt = 0;
    logic [15:0] last_data = 16'h0000;

    always @(negedge sys_clk) begin
        if (ifc.pix_wr_en) begin
            wr_cnt    = wr_cnt + 1;
            last_data = ifc.pix_data;
        end
        if (ifc.frame_rst)  rst_cnt  = rst_cnt + 1;
        if (ifc.frame_done) done_cnt = done_cnt + 1;
        if (ifc.frame_rst && ifc.frame_done) both_cnt = both_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ifc.cam_data = b;
        tick();
    endtask

    task automatic send_line(input int nb, input logic [7:0] base);
        ifc.cam_href = 1'b1;
        for (int i = 0; i < nb; i++) send_byte(base + 8'(i));
        ifc.cam_href = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_vsync();
        ifc.cam_vsync = 1'b1;
        repeat (3) tick();
        ifc.cam_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_frame(input logic [7:0] base);
        send_line(8, base);
        send_line(8, base + 8'h08);
        send_vsync();
    endtask

    initial begin
        ifc.cfg_done  = 1'b0;
        ifc.cam_vsync = 1'b0;
        ifc.cam_href  = 1'b0;
        ifc.cam_data  = 8'h00;
        tick();
        tick();
        check_val("rst_wr_en",  32'(ifc.pix_wr_en),  32'd0);
        check_val("rst_data",   32'(ifc.pix_data),   32'h0);
        check_val("rst_fcnt",   32'(ifc.frame_cnt),  32'd0);
        check_val("rst_geom",   32'(ifc.geom_err),   32'd0);
        check_val("rst_frst",   32'(ifc.frame_rst),  32'd0);
        check_val("rst_fdone",  32'(ifc.frame_done), 32'd0);
        check_val("rst_state",  32'(dut.state_q),    32'(ST_WAIT_CFG));

        sys_rst_n    = 1'b1;
        ifc.cfg_done = 1'b1;
        tick();

        // two skipped frames; the second vsync starts capture
        send_frame(8'h00);
        check_val("skip1_wr",   32'(wr_cnt),  32'd0);
        check_val("skip1_frst", 32'(rst_cnt), 32'd0);
        send_frame(8'h40);
        check_val("skip2_wr",    32'(wr_cnt),        32'd0);
        check_val("skip2_frst",  32'(rst_cnt),       32'd1);
        check_val("skip2_state", 32'(dut.state_q),   32'(ST_CAPTURE));
        check_val("skip2_fcnt",  32'(ifc.frame_cnt), 32'd0);

        // first captured frame, with byte-pairing latency checked inline
        ifc.cam_href = 1'b1;
        send_byte(8'hA1);
        send_byte(8'hB2);
        check_val("pair_early", 32'(ifc.pix_wr_en), 32'd0);
        ifc.cam_data = 8'hC3;
        tick();
        check_val("pair_wr_en", 32'(ifc.pix_wr_en), 32'd1);
        check_val("pair_data",  32'(ifc.pix_data),  32'hA1B2);
        send_byte(8'hD4);
        send_byte(8'hE5);
        send_byte(8'hF6);
        send_byte(8'h07);
        send_byte(8'h18);
        ifc.cam_href = 1'b0;
        tick();
        tick();
        send_line(8, 8'h20);
        check_val("f3_last", 32'(last_data), 32'h2627);
        send_vsync();
        check_val("f3_wr",    32'(wr_cnt),        32'd8);
        check_val("f3_done",  32'(done_cnt),      32'd1);
        check_val("f3_both",  32'(both_cnt),      32'd1);
        check_val("f3_frst",  32'(rst_cnt),       32'd2);
        check_val("f3_fcnt",  32'(ifc.frame_cnt), 32'd1);
        check_val("f3_geom",  32'(ifc.geom_err),  32'd0);

        // short line: 7 bytes give 3 words and a geometry error
        send_line(7, 8'h50);
        check_val("short_wr",   32'(wr_cnt),       32'd11);
        check_val("short_geom", 32'(ifc.geom_err), 32'd1);
        send_line(8, 8'h10);
        check_val("after_wr",   32'(wr_cnt),    32'd15);
        check_val("after_data", 32'(last_data), 32'h1617);
        send_vsync();
        check_val("short_fcnt", 32'(ifc.frame_cnt), 32'd2);
        check_val("short_done", 32'(done_cnt),      32'd2);

        // config drop mid-line
        ifc.cam_href = 1'b1;
        send_byte(8'h60);
        send_byte(8'h61);
        send_byte(8'h62);
        ifc.cfg_done = 1'b0;
        tick();
        send_byte(8'h63);
        send_byte(8'h64);
        send_byte(8'h65);
        send_byte(8'h66);
        ifc.cam_href = 1'b0;
        tick();
        tick();
        check_val("drop_wr",    32'(wr_cnt),        32'd16);
        check_val("drop_state", 32'(dut.state_q),   32'(ST_WAIT_CFG));
        check_val("drop_fcnt",  32'(ifc.frame_cnt), 32'd2);
        check_val("drop_geom",  32'(ifc.geom_err),  32'd1);
        ifc.cfg_done = 1'b1;
        send_frame(8'h80);
        check_val("rsk1_wr",    32'(wr_cnt),      32'd16);
        check_val("rsk1_frst",  32'(rst_cnt),     32'd3);
        check_val("rsk1_state", 32'(dut.state_q), 32'(ST_SKIP));
        send_frame(8'h90);
        check_val("rsk2_wr",    32'(wr_cnt),      32'd16);
        check_val("rsk2_frst",  32'(rst_cnt),     32'd4);
        check_val("rsk2_state", 32'(dut.state_q), 32'(ST_CAPTURE));
        send_frame(8'hA0);
        check_val("recap_wr",   32'(wr_cnt),        32'd24);
        check_val("recap_fcnt", 32'(ifc.frame_cnt), 32'd3);

        // asynchronous reset in the middle of a line
        ifc.cam_href = 1'b1;
        send_byte(8'hB0);
        send_byte(8'hB1);
        send_byte(8'hB2);
        check_val("pre_rst_wr_en", 32'(ifc.pix_wr_en), 32'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_val("arst_wr_en", 32'(ifc.pix_wr_en),  32'd0);
        check_val("arst_data",  32'(ifc.pix_data),   32'h0);
        check_val("arst_fcnt",  32'(ifc.frame_cnt),  32'd0);
        check_val("arst_geom",  32'(ifc.geom_err),   32'd0);
        check_val("arst_frst",  32'(ifc.frame_rst),  32'd0);
        check_val("arst_fdone", 32'(ifc.frame_done), 32'd0);
        tick();
        sys_rst_n = 1'b1;
        send_byte(8'hB3);
        send_byte(8'hB4);
        send_byte(8'hB5);
        ifc.cam_href = 1'b0;
        tick();
        tick();
        check_val("arst_partial", 32'(wr_cnt), 32'd24);

        send_frame(8'h00);
        send_frame(8'h00);
        repeat (300) send_frame(8'h30);
        check_val("wrap_fcnt", 32'(ifc.frame_cnt), 32'd44);
        check_val("wrap_geom", 32'(ifc.geom_err),  32'd0);
        check_val("wrap_wr",   32'(wr_cnt),        32'd2424);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ov5640_capture.md
OV5640_CAPTURE -- requirements
Module: ov5640_capture

Interface
REQ-001 Parameter FRAME_SKIP, default 10: number of vsync rising edges discarded after cfg_done before capture starts (minimum 1).
REQ-002 Parameter H_PIXEL, default 640: expected 16-bit words per href line.
REQ-003 Parameter V_PIXEL, default 480: expected href lines per frame.
REQ-004 sys_clk  input  1  camera PCLK; the only clock; all logic on rising edge.
REQ-005 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-006 cfg_done  input  1  sensor register configuration complete; level.
REQ-007 cam_vsync  input  1  frame sync, active high.
REQ-008 cam_href  input  1  line valid, active high.
REQ-009 cam_data  input  8  DVP pixel byte.
REQ-010 pix_wr_en  output  1  one-cycle strobe; pix_data valid; drives wr_fifo_wr_req.
REQ-011 pix_data  output  16  RGB565 word; drives wr_fifo_wr_data.
REQ-012 frame_rst  output  1  one-cycle pulse at each captured frame start; drives wr_rst.
REQ-013 frame_done  output  1  one-cycle pulse when a captured frame closes.
REQ-014 frame_cnt  output  8  count of completed captured frames; wraps 255->0.
REQ-015 geom_err  output  1  sticky geometry-error flag.

Function
REQ-016 cam_vsync, cam_href and cam_data SHALL be registered once (stage S1) before any use; vsync_rise = S1 vsync high and its previous value low.
REQ-017 FSM states: WAIT_CFG (reset state), SKIP, CAPTURE.
REQ-018 WAIT_CFG -> SKIP when cfg_done=1; the skip counter is cleared on entry.
REQ-019 In SKIP, each vsync_rise increments the skip counter; the FRAME_SKIP-th vsync_rise moves to CAPTURE, and that same edge starts the first captured frame (frame_rst pulses).
REQ-020 cfg_done=0 in any state SHALL force WAIT_CFG on the next edge. Pairing, pixel and line counters clear; no further pix_wr_en; frame_cnt and geom_err hold.
REQ-021 In CAPTURE, with S1 href high, bytes pair alternately: the first byte goes to pix_data[15:8], the second to [7:0].
REQ-022 pix_wr_en SHALL assert exactly one cycle per second byte, with pix_data updated in the same cycle. Latency: 2 rising edges from the second byte at the port.
REQ-023 The pairing phase SHALL reset to "first byte" whenever S1 href is low; an unpaired trailing byte is discarded.
REQ-024 The pixel counter (11 bits) increments per pix_wr_en and clears on S1 href falling edge. The line counter (10 bits) increments on each href falling edge in CAPTURE.
REQ-025 An href falling edge with pixel count != H_PIXEL, or with an unpaired byte, SHALL set geom_err.
REQ-026 On vsync_rise in CAPTURE after at least one captured frame start:
- frame_done pulses;
- frame_cnt increments;
- geom_err sets if line count != V_PIXEL;
- line counter clears;
- frame_rst pulses in the same cycle.
REQ-027 frame_rst and frame_done SHALL be asserted no earlier than one cycle after the last pix_wr_en of the previous frame.
REQ-028 href high while S1 vsync is high SHALL be ignored: no writes, no counting.
REQ-029 geom_err SHALL clear only on reset.

Reset
REQ-030 Asynchronous assertion SHALL clear:
- state to WAIT_CFG;
- all S1 registers and counters to 0;
- pix_data=16'h0000, frame_cnt=0;
- pix_wr_en, frame_rst, frame_done, geom_err to 0.
REQ-031 Reset release mid-line SHALL not emit a partial word. Capture resumes only via the full WAIT_CFG/SKIP sequence.

Structure
REQ-032 FSM state encodings and the H_PIXEL/V_PIXEL/FRAME_SKIP defaults SHALL live in a shared package used by ov5640_capture and the display read side.
REQ-033 Single module with no sub-modules; the edge detectors are inline.

Verification (H_PIXEL=4, V_PIXEL=2, FRAME_SKIP=2)
REQ-034 Frame skip: cfg_done=1, then 3 frames of 2 lines x 8 bytes.
- Frames 1 and 2 produce no pix_wr_en.
- The 2nd vsync_rise gives frame_rst=1.
- Frame 3 gives 8 pix_wr_en.
REQ-035 Byte pairing: bytes 8'hA1, 8'hB2 -> pix_data=16'hA1B2 with pix_wr_en=1, two edges after 8'hB2.
REQ-036 Short line: 7 bytes then href low.
- 3 writes occur.
- geom_err=1 after the href falling edge.
- The next line pairs from the first byte.
REQ-037 Frame close: 2 good lines then vsync_rise.
- frame_done=1 and frame_rst=1 in the same cycle.
- frame_cnt 0->1.
- geom_err stays 0.
REQ-038 Config drop: cfg_done=0 mid-line.
- No further pix_wr_en.
- State returns to WAIT_CFG.
- Capture restarts only after 2 further vsync_rise.
REQ-039 Async reset mid-line: all outputs 0 immediately. After release, 300 frames are counted and frame_cnt wraps to 44.
